// File: rtl/noc_terminal_if.sv
// Host-side and router-side handshake bundle of a NoC terminal.
// Latency: none, wires only.
// Backpressure: send_ready/recv_ready valid-ready on the host side, 4-phase req/ack on the router side.
interface noc_terminal_if #(
  parameter int SIZE = 8
);
  // host inject side
  logic            send_valid;
  logic            send_ready;
  logic [SIZE-1:0] send_data;
  // router rx slice (terminal is requester)
  logic            inj_req;
  logic            inj_ack;
  logic [SIZE-1:0] inj_data;
  // router tx slice (terminal is acknowledger)
  logic            ej_req;
  logic            ej_ack;
  logic [SIZE-1:0] ej_data;
  // host eject side
  logic            recv_valid;
  logic            recv_ready;
  logic [SIZE-1:0] recv_data;

  // terminal view
  modport slave (
    input  send_valid, send_data, inj_ack, ej_req, ej_data, recv_ready,
    output send_ready, inj_req, inj_data, ej_ack, recv_valid, recv_data
  );

  // host/router view
  modport master (
    output send_valid, send_data, inj_ack, ej_req, ej_data, recv_ready,
    input  send_ready, inj_req, inj_data, ej_ack, recv_valid, recv_data
  );
endinterface

// File: rtl/noc_terminal.sv
// NoC endpoint on a router Local port: queued injection, single-flit ejection buffer, saturating stats.
// Latency: push-to-inj_req 1 clk minimum, 4 clk per injected flit; ej_req-to-ej_ack 1 clk when buffer free.
// Backpressure: send_ready drops when the queue is full; ej_ack is withheld while recv_data is unconsumed.
module noc_terminal #(
  parameter int ID               = -1,
  parameter int SIZE             = 8,
  parameter int DESTINATION_BITS = 4,
  parameter int DEPTH_LOG2       = 2,
  parameter int COUNT_BITS       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  noc_terminal_if.slave         term,
  output logic [COUNT_BITS-1:0] sent_count,
  output logic [COUNT_BITS-1:0] recv_count,
  output logic [COUNT_BITS-1:0] misroute_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DESTINATION_BITS-1:0] MY_DEST = DESTINATION_BITS'(ID);

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_DROP} tx_state_t;
  typedef enum logic {RX_IDLE, RX_HOLD} rx_state_t;

  function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---------------- injection queue ----------------
  logic [SIZE-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                q_full;
  logic                q_empty;
  logic                push;
  logic                pop;

  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  // Gated by reset so the host never sees a slot that is about to be discarded.
  assign term.send_ready = !q_full && !reset;
  assign push = term.send_valid && term.send_ready;

  // Queue storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= term.send_data;
  end

  // Queue pointers with wrap bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- TX FSM (4-phase requester) ----------------
  tx_state_t       tx_state;
  tx_state_t       tx_next;
  logic            inj_req_q;
  logic            inj_req_next;
  logic [SIZE-1:0] inj_data_q;
  logic [SIZE-1:0] inj_data_next;
  logic            sent_inc;

  assign term.inj_req  = inj_req_q;
  assign term.inj_data = inj_data_q;

  // TX next state: raise req on a queued flit, pop on ack, wait for ack to return to zero.
  always_comb begin
    tx_next       = tx_state;
    inj_req_next  = inj_req_q;
    inj_data_next = inj_data_q;
    pop           = 1'b0;
    sent_inc      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!q_empty && !term.inj_ack) begin
          tx_next       = TX_REQ;
          inj_req_next  = 1'b1;
          inj_data_next = mem[rd_ptr[DEPTH_LOG2-1:0]];
        end
      end
      TX_REQ: begin
        if (term.inj_ack) begin
          tx_next      = TX_DROP;
          inj_req_next = 1'b0;
          pop          = 1'b1;
          sent_inc     = 1'b1;
        end
      end
      TX_DROP: begin
        if (!term.inj_ack) tx_next = TX_IDLE;
      end
      default: begin
        tx_next      = TX_IDLE;
        inj_req_next = 1'b0;
      end
    endcase
  end

  // TX state, request/data registers and sent counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state   <= TX_IDLE;
      inj_req_q  <= 1'b0;
      inj_data_q <= '0;
      sent_count <= '0;
    end else begin
      tx_state   <= tx_next;
      inj_req_q  <= inj_req_next;
      inj_data_q <= inj_data_next;
      if (sent_inc) sent_count <= sat_inc(sent_count);
    end
  end

  // ---------------- RX FSM (4-phase acknowledger) ----------------
  rx_state_t       rx_state;
  rx_state_t       rx_next;
  logic            ej_ack_q;
  logic            ej_ack_next;
  logic            recv_valid_q;
  logic [SIZE-1:0] recv_data_q;
  logic            capture;

  assign term.ej_ack     = ej_ack_q;
  assign term.recv_valid = recv_valid_q;
  assign term.recv_data  = recv_data_q;

  // RX next state: accept only when the holding register is free or being drained this edge.
  always_comb begin
    rx_next     = rx_state;
    ej_ack_next = ej_ack_q;
    capture     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (term.ej_req && (!recv_valid_q || term.recv_ready)) begin
          capture     = 1'b1;
          ej_ack_next = 1'b1;
          rx_next     = RX_HOLD;
        end
      end
      RX_HOLD: begin
        if (!term.ej_req) begin
          ej_ack_next = 1'b0;
          rx_next     = RX_IDLE;
        end
      end
      default: begin
        rx_next     = RX_IDLE;
        ej_ack_next = 1'b0;
      end
    endcase
  end

  // RX state, ack and holding register; a capture takes priority over a host pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state       <= RX_IDLE;
      ej_ack_q       <= 1'b0;
      recv_valid_q   <= 1'b0;
      recv_data_q    <= '0;
      recv_count     <= '0;
      misroute_count <= '0;
    end else begin
      rx_state <= rx_next;
      ej_ack_q <= ej_ack_next;
      if (capture) begin
        recv_valid_q <= 1'b1;
        recv_data_q  <= term.ej_data;
        recv_count   <= sat_inc(recv_count);
        if (term.ej_data[DESTINATION_BITS-1:0] != MY_DEST)
          misroute_count <= sat_inc(misroute_count);
      end else if (recv_valid_q && term.recv_ready) begin
        recv_valid_q <= 1'b0;
      end
    end
  end

endmodule
